// File: rtl/s1c88_bus_responder_if.sv
// -----------------------------------------------------------------------------
// s1c88_bus_responder_if
// CPU-side bus bundle between the S1C88 core and its target-side responder.
//   bus_address  [23:0]  CPU address
//   bus_status   [1:0]   0 idle, 1 IRQ read, 2 mem write, 3 mem read
//   bus_read / bus_write  CPU strobes (exactly one high = a request)
//   bus_wdata    [7:0]   CPU write data
//   irq_vector   [7:0]   vector byte returned on an IRQ read
//   bus_data_out [7:0]   read data to the CPU
//   bus_ready / bus_error one-cycle completion / error pulses
// master = CPU side, slave = responder side.
// -----------------------------------------------------------------------------
interface s1c88_bus_responder_if;
  logic [23:0] bus_address;
  logic [1:0]  bus_status;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_wdata;
  logic [7:0]  irq_vector;
  logic [7:0]  bus_data_out;
  logic        bus_ready;
  logic        bus_error;

  modport master (
    output bus_address, bus_status, bus_read, bus_write, bus_wdata, irq_vector,
    input  bus_data_out, bus_ready, bus_error
  );

  modport slave (
    input  bus_address, bus_status, bus_read, bus_write, bus_wdata, irq_vector,
    output bus_data_out, bus_ready, bus_error
  );
endinterface

// File: rtl/s1c88_bus_responder.sv
// -----------------------------------------------------------------------------
// s1c88_bus_responder
// Target-side responder for the S1C88 external bus. A request (exactly one of
// bus_read/bus_write high, sampled in IDLE) is decoded into BIOS ROM, work RAM,
// I/O registers or cartridge space and run against that target. Internal
// targets and IRQ-acknowledge reads complete one cycle after the request;
// cartridge accesses wait for cart_ack or abort after CART_TIMEOUT cycles.
//
// Ports:
//   clk, reset (async, active-low)
//   bus                       CPU bus bundle (slave modport)
//   bios_address/bios_rdata   BIOS ROM, 12-bit offset
//   ram_*                     work RAM, 12-bit offset, ram_we single-cycle
//   io_*                      I/O registers, 8-bit offset, io_we/io_re single-cycle
//   cart_*                    cartridge, full 24-bit address, req/ack handshake
// All outputs are registered.
// -----------------------------------------------------------------------------
module s1c88_bus_responder #(
  parameter logic [23:0] RAM_BASE     = 24'h001000,
  parameter logic [23:0] IO_BASE      = 24'h002000,
  parameter logic [23:0] CART_BASE    = 24'h002100,
  parameter int          CART_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  s1c88_bus_responder_if.slave        bus,
  output logic [11:0]                 bios_address,
  input  logic [7:0]                  bios_rdata,
  output logic [11:0]                 ram_address,
  output logic [7:0]                  ram_wdata,
  output logic                        ram_we,
  input  logic [7:0]                  ram_rdata,
  output logic [7:0]                  io_address,
  output logic [7:0]                  io_wdata,
  output logic                        io_we,
  output logic                        io_re,
  input  logic [7:0]                  io_rdata,
  output logic [23:0]                 cart_address,
  output logic [7:0]                  cart_wdata,
  output logic                        cart_we,
  output logic                        cart_req,
  input  logic                        cart_ack,
  input  logic [7:0]                  cart_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, CART_WAIT, RESPOND} state_t;
  typedef enum logic [2:0] {TGT_IRQ, TGT_BIOS, TGT_RAM, TGT_IO, TGT_CART} target_t;

  localparam int CNT_W = $clog2(CART_TIMEOUT + 1);

  state_t           state_reg;
  target_t          target_reg;
  logic             is_write_reg;
  logic             resp_error_reg;
  logic [CNT_W-1:0] timeout_cnt_reg;

  logic             req_single;
  logic             req_both;
  logic             stray_req;
  target_t          decode_target;
  logic [11:0]      ram_offset;
  logic [7:0]       io_offset;

  assign req_single = bus.bus_read ^ bus.bus_write;
  assign req_both   = bus.bus_read & bus.bus_write;
  // Any strobe activity while an access is in flight is a protocol error.
  assign stray_req  = (state_reg != IDLE) && (bus.bus_read || bus.bus_write);

  // Offsets only need the low bits: subtracting the truncated base gives the
  // same result as a full-width subtract followed by truncation.
  assign ram_offset = bus.bus_address[11:0] - RAM_BASE[11:0];
  assign io_offset  = bus.bus_address[7:0] - IO_BASE[7:0];

  always_comb begin
    decode_target = TGT_CART;
    if (bus.bus_status == 2'd1)
      decode_target = TGT_IRQ;
    else if (bus.bus_address < RAM_BASE)
      decode_target = TGT_BIOS;
    else if (bus.bus_address < IO_BASE)
      decode_target = TGT_RAM;
    else if (bus.bus_address < CART_BASE)
      decode_target = TGT_IO;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      target_reg       <= TGT_IRQ;
      is_write_reg     <= 1'b0;
      resp_error_reg   <= 1'b0;
      timeout_cnt_reg  <= '0;
      bus.bus_data_out <= 8'hFF;
      bus.bus_ready    <= 1'b0;
      bus.bus_error    <= 1'b0;
      bios_address     <= '0;
      ram_address      <= '0;
      ram_wdata        <= '0;
      ram_we           <= 1'b0;
      io_address       <= '0;
      io_wdata         <= '0;
      io_we            <= 1'b0;
      io_re            <= 1'b0;
      cart_address     <= '0;
      cart_wdata       <= '0;
      cart_we          <= 1'b0;
      cart_req         <= 1'b0;
    end else begin
      // Pulses and single-cycle strobes default low. The stray-request error
      // is masked by its own previous value so it can never stretch.
      bus.bus_ready <= 1'b0;
      bus.bus_error <= stray_req & ~bus.bus_error;
      ram_we        <= 1'b0;
      io_we         <= 1'b0;
      io_re         <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (req_both) begin
            bus.bus_error <= ~bus.bus_error;
          end else if (req_single) begin
            target_reg   <= decode_target;
            is_write_reg <= bus.bus_write;
            case (decode_target)
              TGT_BIOS: begin
                bios_address <= bus.bus_address[11:0];
                state_reg    <= ACCESS;
              end
              TGT_RAM: begin
                ram_address <= ram_offset;
                ram_wdata   <= bus.bus_wdata;
                ram_we      <= bus.bus_write;
                state_reg   <= ACCESS;
              end
              TGT_IO: begin
                io_address <= io_offset;
                io_wdata   <= bus.bus_wdata;
                io_we      <= bus.bus_write;
                io_re      <= bus.bus_read;
                state_reg  <= ACCESS;
              end
              TGT_CART: begin
                cart_address    <= bus.bus_address;
                cart_wdata      <= bus.bus_wdata;
                cart_we         <= bus.bus_write;
                cart_req        <= 1'b1;
                timeout_cnt_reg <= '0;
                state_reg       <= CART_WAIT;
              end
              default: begin
                // IRQ acknowledge touches no target.
                state_reg <= ACCESS;
              end
            endcase
          end
        end

        ACCESS: begin
          bus.bus_ready <= 1'b1;
          if (!is_write_reg) begin
            case (target_reg)
              TGT_IRQ:  bus.bus_data_out <= bus.irq_vector;
              TGT_BIOS: bus.bus_data_out <= bios_rdata;
              TGT_RAM:  bus.bus_data_out <= ram_rdata;
              TGT_IO:   bus.bus_data_out <= io_rdata;
              default:  bus.bus_data_out <= bus.bus_data_out;
            endcase
          end
          // ROM writes are dropped but still acknowledged, flagged as errors.
          if (is_write_reg && target_reg == TGT_BIOS)
            bus.bus_error <= 1'b1;
          state_reg <= IDLE;
        end

        CART_WAIT: begin
          if (cart_ack) begin
            if (!is_write_reg)
              bus.bus_data_out <= cart_rdata;
            cart_req       <= 1'b0;
            cart_we        <= 1'b0;
            resp_error_reg <= 1'b0;
            state_reg      <= RESPOND;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            if (timeout_cnt_reg == CNT_W'(CART_TIMEOUT - 1)) begin
              cart_req         <= 1'b0;
              cart_we          <= 1'b0;
              bus.bus_data_out <= 8'hFF;
              resp_error_reg   <= 1'b1;
              state_reg        <= RESPOND;
            end
          end
        end

        RESPOND: begin
          bus.bus_ready   <= 1'b1;
          if (resp_error_reg)
            bus.bus_error <= 1'b1;
          timeout_cnt_reg <= '0;
          state_reg       <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s1c88_bus_responder.sv
module tb_s1c88_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] bios_address;
  logic [7:0]  bios_rdata;
  logic [11:0] ram_address;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [7:0]  io_address;
  logic [7:0]  io_wdata;
  logic        io_we;
  logic        io_re;
  logic [7:0]  io_rdata;
  logic [23:0] cart_address;
  logic [7:0]  cart_wdata;
  logic        cart_we;
  logic        cart_req;
  logic        cart_ack;
  logic [7:0]  cart_rdata;

  int checks = 0;
  int failures = 0;

  s1c88_bus_responder_if bus_if ();

  s1c88_bus_responder dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if),
    .bios_address (bios_address),
    .bios_rdata   (bios_rdata),
    .ram_address  (ram_address),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata),
    .io_address   (io_address),
    .io_wdata     (io_wdata),
    .io_we        (io_we),
    .io_re        (io_re),
    .io_rdata     (io_rdata),
    .cart_address (cart_address),
    .cart_wdata   (cart_wdata),
    .cart_we      (cart_we),
    .cart_req     (cart_req),
    .cart_ack     (cart_ack),
    .cart_rdata   (cart_rdata)
  );

  always #5 clk = ~clk;

  // Work RAM model: write on the clock, read straight from the current address.
  logic [7:0] ram_mem [0:4095];
  always @(posedge clk) if (ram_we) ram_mem[ram_address] <= ram_wdata;
  assign ram_rdata = ram_mem[ram_address];

  // tgt: 0 IRQ, 1 BIOS, 2 RAM, 3 I/O; exp_stb = {ram_we, io_we, io_re} at T0
  typedef struct {
    logic [1:0]  status;
    logic        rd;
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          tgt;
    logic [11:0] exp_taddr;
    logic [2:0]  exp_stb;
    logic [7:0]  exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request just after an edge; the next edge is T0. Returns at T0+1
  // with the strobes released.
  task automatic request(input logic [1:0] st, input logic rd, input logic wr,
                         input logic [23:0] addr, input logic [7:0] wd);
    bus_if.bus_status  = st;
    bus_if.bus_read    = rd;
    bus_if.bus_write   = wr;
    bus_if.bus_address = addr;
    bus_if.bus_wdata   = wd;
    tick();
    bus_if.bus_read   = 1'b0;
    bus_if.bus_write  = 1'b0;
    bus_if.bus_status = 2'd0;
  endtask

  initial begin
    vec_t v;
    //             st  rd wr  addr         wd     rdata  tgt taddr    stb     data   err
    vecs[0]  = '{2'd3, 1, 0, 24'h000010, 8'h00, 8'hA5, 1, 12'h010, 3'b000, 8'hA5, 1'b0};
    vecs[1]  = '{2'd2, 0, 1, 24'h001234, 8'h3C, 8'h00, 2, 12'h234, 3'b100, 8'hA5, 1'b0};
    vecs[2]  = '{2'd3, 1, 0, 24'h001234, 8'h00, 8'h00, 2, 12'h234, 3'b000, 8'h3C, 1'b0};
    vecs[3]  = '{2'd1, 1, 0, 24'h001234, 8'h00, 8'h0E, 0, 12'h000, 3'b000, 8'h0E, 1'b0};
    vecs[4]  = '{2'd2, 0, 1, 24'h000FFF, 8'h77, 8'h00, 1, 12'hFFF, 3'b000, 8'h0E, 1'b1};
    vecs[5]  = '{2'd3, 1, 0, 24'h000FFF, 8'h00, 8'h11, 1, 12'hFFF, 3'b000, 8'h11, 1'b0};
    vecs[6]  = '{2'd2, 0, 1, 24'h001000, 8'h99, 8'h00, 2, 12'h000, 3'b100, 8'h11, 1'b0};
    vecs[7]  = '{2'd3, 1, 0, 24'h001000, 8'h00, 8'h00, 2, 12'h000, 3'b000, 8'h99, 1'b0};
    vecs[8]  = '{2'd2, 0, 1, 24'h001FFF, 8'h42, 8'h00, 2, 12'hFFF, 3'b100, 8'h99, 1'b0};
    vecs[9]  = '{2'd3, 1, 0, 24'h001FFF, 8'h00, 8'h00, 2, 12'hFFF, 3'b000, 8'h42, 1'b0};
    vecs[10] = '{2'd2, 0, 1, 24'h002000, 8'h5C, 8'h00, 3, 12'h000, 3'b010, 8'h42, 1'b0};
    vecs[11] = '{2'd3, 1, 0, 24'h0020FF, 8'h00, 8'h6D, 3, 12'h0FF, 3'b001, 8'h6D, 1'b0};

    reset = 1'b0;
    bus_if.bus_address = '0;
    bus_if.bus_status  = '0;
    bus_if.bus_read    = 1'b0;
    bus_if.bus_write   = 1'b0;
    bus_if.bus_wdata   = '0;
    bus_if.irq_vector  = '0;
    bios_rdata = '0;
    io_rdata   = '0;
    cart_ack   = 1'b0;
    cart_rdata = '0;

    repeat (3) tick();
    check("rst_data", {24'h0, bus_if.bus_data_out}, 32'hFF);
    check("rst_ready", {31'h0, bus_if.bus_ready}, 32'h0);
    check("rst_error", {31'h0, bus_if.bus_error}, 32'h0);
    check("rst_cart_req", {31'h0, cart_req}, 32'h0);
    check("rst_strobes", {28'h0, ram_we, io_we, io_re, cart_we}, 32'h0);
    check("rst_addr", {8'h0, cart_address}, 32'h0);
    reset = 1'b1;
    tick();

    // ---------------- internal targets, table driven ----------------
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      bios_rdata        = v.rdata;
      io_rdata          = v.rdata;
      bus_if.irq_vector = v.rdata;
      request(v.status, v.rd, v.wr, v.addr, v.wdata);
      $display("vec%0d st=%0d rd=%0d wr=%0d addr=%06h wdata=%02h", i, v.status, v.rd, v.wr, v.addr, v.wdata);
      case (v.tgt)
        1: check($sformatf("vec%0d_bios_addr", i), {20'h0, bios_address}, {20'h0, v.exp_taddr});
        2: check($sformatf("vec%0d_ram_addr", i), {20'h0, ram_address}, {20'h0, v.exp_taddr});
        3: check($sformatf("vec%0d_io_addr", i), {24'h0, io_address}, {20'h0, v.exp_taddr});
        default: ;
      endcase
      if (v.tgt == 2 && v.wr) check($sformatf("vec%0d_ram_wdata", i), {24'h0, ram_wdata}, {24'h0, v.wdata});
      if (v.tgt == 3 && v.wr) check($sformatf("vec%0d_io_wdata", i), {24'h0, io_wdata}, {24'h0, v.wdata});
      check($sformatf("vec%0d_t0_strobes", i), {28'h0, ram_we, io_we, io_re, cart_req}, {28'h0, v.exp_stb, 1'b0});
      check($sformatf("vec%0d_t0_ready", i), {31'h0, bus_if.bus_ready}, 32'h0);
      tick();
      check($sformatf("vec%0d_t1_data", i), {24'h0, bus_if.bus_data_out}, {24'h0, v.exp_data});
      check($sformatf("vec%0d_t1_ready", i), {31'h0, bus_if.bus_ready}, 32'h1);
      check($sformatf("vec%0d_t1_error", i), {31'h0, bus_if.bus_error}, {31'h0, v.exp_err});
      check($sformatf("vec%0d_t1_strobes", i), {29'h0, ram_we, io_we, io_re}, 32'h0);
      tick();
      check($sformatf("vec%0d_t2_pulses", i), {30'h0, bus_if.bus_ready, bus_if.bus_error}, 32'h0);
    end

    // ---------------- cartridge timeout (first cartridge address) ----------------
    $display("seq cart_timeout addr=002100");
    request(2'd3, 1'b1, 1'b0, 24'h002100, 8'h00);
    check("to_req_t0", {31'h0, cart_req}, 32'h1);
    check("to_addr", {8'h0, cart_address}, 32'h002100);
    for (int k = 1; k <= 15; k++) tick();
    check("to_req_t15", {31'h0, cart_req}, 32'h1);
    check("to_ready_t15", {31'h0, bus_if.bus_ready}, 32'h0);
    tick();
    check("to_req_t16", {31'h0, cart_req}, 32'h0);
    check("to_data_t16", {24'h0, bus_if.bus_data_out}, 32'hFF);
    check("to_ready_t16", {31'h0, bus_if.bus_ready}, 32'h0);
    tick();
    check("to_ready_err_t17", {30'h0, bus_if.bus_ready, bus_if.bus_error}, 32'h3);
    tick();
    check("to_pulses_t18", {30'h0, bus_if.bus_ready, bus_if.bus_error}, 32'h0);
    cart_ack = 1'b1;
    tick();
    cart_ack = 1'b0;
    check("late_ack_ignored", {29'h0, bus_if.bus_ready, bus_if.bus_error, cart_req}, 32'h0);
    tick();
    check("late_ack_ignored2", {30'h0, bus_if.bus_ready, bus_if.bus_error}, 32'h0);

    // ---------------- both strobes high ----------------
    $display("seq both_strobes addr=001000");
    request(2'd2, 1'b1, 1'b1, 24'h001000, 8'hAA);
    check("both_error_t0", {31'h0, bus_if.bus_error}, 32'h1);
    check("both_no_access", {29'h0, ram_we, cart_req, bus_if.bus_ready}, 32'h0);
    tick();
    check("both_pulses_t1", {30'h0, bus_if.bus_ready, bus_if.bus_error}, 32'h0);

    // ---------------- cartridge read, ack after 5 cycles, stray request ----------------
    $display("seq cart_read addr=004000 ack_after=5");
    cart_rdata = 8'h5A;
    request(2'd3, 1'b1, 1'b0, 24'h004000, 8'h00);
    check("cr_req_t0", {31'h0, cart_req}, 32'h1);
    check("cr_addr", {8'h0, cart_address}, 32'h004000);
    check("cr_we", {31'h0, cart_we}, 32'h0);
    tick();
    bus_if.bus_read = 1'b1;
    tick();
    bus_if.bus_read = 1'b0;
    check("cr_stray_error", {31'h0, bus_if.bus_error}, 32'h1);
    tick();
    check("cr_stray_error_end", {31'h0, bus_if.bus_error}, 32'h0);
    tick();
    check("cr_req_t4", {31'h0, cart_req}, 32'h1);
    cart_ack = 1'b1;
    tick();
    cart_ack = 1'b0;
    check("cr_req_dropped", {31'h0, cart_req}, 32'h0);
    check("cr_ready_at_ack", {31'h0, bus_if.bus_ready}, 32'h0);
    tick();
    check("cr_data", {24'h0, bus_if.bus_data_out}, 32'h5A);
    check("cr_ready_err", {30'h0, bus_if.bus_ready, bus_if.bus_error}, 32'h2);
    tick();
    check("cr_pulses_end", {30'h0, bus_if.bus_ready, bus_if.bus_error}, 32'h0);

    // ---------------- cartridge write, quick ack ----------------
    $display("seq cart_write addr=800000 wdata=E1");
    request(2'd2, 1'b0, 1'b1, 24'h800000, 8'hE1);
    check("cw_req_we", {30'h0, cart_req, cart_we}, 32'h3);
    check("cw_wdata", {24'h0, cart_wdata}, 32'hE1);
    cart_ack = 1'b1;
    tick();
    cart_ack = 1'b0;
    check("cw_req_we_dropped", {30'h0, cart_req, cart_we}, 32'h0);
    tick();
    check("cw_ready", {30'h0, bus_if.bus_ready, bus_if.bus_error}, 32'h2);
    check("cw_data_hold", {24'h0, bus_if.bus_data_out}, 32'h5A);
    tick();

    // ---------------- reset during CART_WAIT ----------------
    $display("seq reset_in_cart_wait addr=7FFFFF");
    request(2'd3, 1'b1, 1'b0, 24'h7FFFFF, 8'h00);
    tick();
    check("rw_req_before", {31'h0, cart_req}, 32'h1);
    reset = 1'b0;
    #1;
    check("rw_req_immediate", {31'h0, cart_req}, 32'h0);
    check("rw_data", {24'h0, bus_if.bus_data_out}, 32'hFF);
    check("rw_addr", {8'h0, cart_address}, 32'h0);
    tick();
    tick();
    check("rw_no_ready", {30'h0, bus_if.bus_ready, cart_req}, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    check("rw_no_ready_after", {29'h0, bus_if.bus_ready, bus_if.bus_error, cart_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s1c88_bus_responder.md
Name: s1c88_bus_responder

Overview:
Target-side responder for the S1C88 core's external bus. It samples the CPU's address, bus_status and read/write strobes, decodes the 24-bit address into BIOS ROM, work RAM, I/O register and cartridge regions, and runs the access. Read data returns on bus_data_out with a bus_ready pulse; interrupt-acknowledge reads are answered with the pending vector. It sits between the CPU and the memory/peripheral blocks in the system top level.

Parameters:
RAM_BASE, 24'h001000, first RAM address; BIOS occupies 24'h000000 .. RAM_BASE-1 (4 KiB)
IO_BASE, 24'h002000, first I/O register address; RAM occupies RAM_BASE .. IO_BASE-1 (4 KiB)
CART_BASE, 24'h002100, first cartridge address; I/O occupies IO_BASE .. CART_BASE-1 (256 B)
CART_TIMEOUT, 16, maximum cycles to wait for cart_ack before aborting

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset (0 = reset)
bus_address  in  24  CPU address
bus_status  in  2  0 idle, 1 IRQ read, 2 mem write, 3 mem read
bus_read  in  1  CPU read strobe
bus_write  in  1  CPU write strobe
bus_wdata  in  8  CPU write data
bus_data_out  out  8  read data to CPU
bus_ready  out  1  one-cycle completion pulse
bus_error  out  1  one-cycle error pulse
irq_vector  in  8  vector byte returned on IRQ read
bios_address  out  12  ; bios_rdata  in  8  (rdata valid one cycle after address)
ram_address  out  12 ; ram_wdata out 8 ; ram_we out 1 ; ram_rdata in 8  (1-cycle read)
io_address  out  8 ; io_wdata out 8 ; io_we out 1 ; io_re out 1 ; io_rdata in 8  (1-cycle read)
cart_address  out  24 ; cart_wdata out 8 ; cart_we out 1 ; cart_req out 1 ; cart_ack in 1 ; cart_rdata in 8

Behaviour:
- Reset (reset=0, immediate): state IDLE; bus_data_out=8'hFF; bus_ready, bus_error, ram_we, io_we, io_re, cart_req, cart_we=0; all address/wdata outputs 0; timeout counter 0. Reset mid-access drops cart_req immediately and produces no ready pulse.
- Request = bus_read XOR bus_write sampled high in IDLE. Both high: no access, bus_error pulse next cycle. Any request sampled outside IDLE: ignored, bus_error pulse.
- States: IDLE, ACCESS, CART_WAIT, RESPOND.
- IDLE, request at edge T0: latch address, wdata, direction; decode; drive target address (and strobe) from T0. Internal target or IRQ read -> ACCESS. Cartridge -> CART_WAIT with cart_req=1.
- Decode priority: bus_status==1 -> IRQ read, no target touched, response = irq_vector. Else address < RAM_BASE -> BIOS; < IO_BASE -> RAM; < CART_BASE -> I/O; else cartridge. Internal offsets = address minus region base, truncated to port width.
- Writes to BIOS: discarded, complete normally, bus_error pulse alongside bus_ready.
- ram_we/io_we/io_re: exactly one cycle (T0..T1).
- ACCESS, edge T1: capture target rdata (reads) into bus_data_out; bus_ready=1 for T1..T2; -> IDLE. Internal access latency: ready at T0+1 cycle.
- CART_WAIT: cart_req, cart_we, cart_address, cart_wdata held stable until cart_ack sampled high; on that edge capture cart_rdata (reads), drop cart_req -> RESPOND; RESPOND pulses bus_ready, -> IDLE. cart_ack on the same edge as the request is not seen (request starts at T0).
- Timeout: counter increments each CART_WAIT cycle; on reaching CART_TIMEOUT without ack, drop cart_req, bus_data_out=8'hFF, -> RESPOND with bus_error pulse coincident with bus_ready. cart_ack later in IDLE ignored.
- bus_data_out holds its last value between reads (writes do not change it).
- bus_ready and bus_error are never high for more than one consecutive cycle each.

Test Plan:
- Reset release, then read 24'h000010 with bios_rdata=8'hA5 -> bios_address=12'h010 at T0, bus_data_out=8'hA5 and bus_ready pulse at T1; no error.
- Write 8'h3C to 24'h001234 -> ram_address=12'h234, ram_wdata=8'h3C, ram_we single cycle; readback returns 8'h3C at T1.
- IRQ read (bus_status=1, bus_read=1, irq_vector=8'h0E) -> bus_data_out=8'h0E, ready at T1; no target strobe asserted.
- Cartridge read 24'h004000, cart_ack after 5 cycles with cart_rdata=8'h5A -> cart_req held 5 cycles, 8'h5A returned, ready one cycle after ack.
- Cartridge read with no ack -> after 16 cycles cart_req=0, bus_data_out=8'hFF, bus_ready and bus_error pulse together.
- bus_read and bus_write both high; and reset=0 asserted during CART_WAIT -> error pulse with no access; reset drops cart_req same cycle, outputs at reset values, no ready pulse.
